// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared constants for the ALU operand-fetch stage: datapath widths, ALU
// select codes, instruction field positions and a small decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int ADDR_W  = 3;
    localparam int SEL_W   = 3;
    localparam int INSTR_W = 32;

    // Instruction field positions
    localparam int SEL_LSB      = 24;
    localparam int IMM_FLAG_BIT = 27;
    localparam int DEST_LSB     = 16;
    localparam int SRC1_LSB     = 8;
    localparam int SRC2_LSB     = 0;
    localparam int IMM8_LSB     = 0;

    typedef enum logic [SEL_W-1:0] {
        SEL_NEG0 = 3'b000,
        SEL_NEG1 = 3'b001,
        SEL_ADD  = 3'b010,
        SEL_SUB  = 3'b011,
        SEL_AND  = 3'b100,
        SEL_OR   = 3'b101,
        SEL_XOR  = 3'b111
    } alu_sel_e;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              imm;
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [DATA_W-1:0] imm8;
    } instr_t;

    // src2 and imm8 overlap in the encoding; both are extracted and the
    // imm flag decides which one is meaningful.
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] instr);
        instr_t d;
        d.sel  = instr[SEL_LSB  +: SEL_W];
        d.imm  = instr[IMM_FLAG_BIT];
        d.dest = instr[DEST_LSB +: ADDR_W];
        d.src1 = instr[SRC1_LSB +: ADDR_W];
        d.src2 = instr[SRC2_LSB +: ADDR_W];
        d.imm8 = instr[IMM8_LSB +: DATA_W];
        return d;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Bundles the operand stage's instruction handshake, operand output
// handshake and writeback port.
//   master : the environment (instruction source, ALU consumer, writeback)
//   slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    // instruction input handshake
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;

    // registered operands to the ALU
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [SEL_W-1:0]    alu_sel;
    logic [ADDR_W-1:0]   alu_dest;

    // ALU result writeback
    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, alu_a, alu_b, alu_sel, alu_dest
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, alu_a, alu_b, alu_sel, alu_dest
    );

endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_reg_file
// NREG x DATA_W register file: two combinational read ports, one write port
// updated on the rising edge, synchronous active-low clear.
//   clk, reset_n           clock, synchronous active-low clear
//   rd_addr_a / rd_data_a  read port A (combinational)
//   rd_addr_b / rd_data_b  read port B (combinational)
//   wr_en, wr_addr, wr_data write port
// Reads are combinational so the top can bypass and register in the same
// cycle; a block-RAM style registered read would add a stage of latency.
// ---------------------------------------------------------------------------
module alu_operand_stage_reg_file
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_reg [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = regs_reg[rd_addr_a];
    assign rd_data_b = regs_reg[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Operand-fetch stage in front of the 8-bit ALU. Accepts one instruction per
// valid/ready handshake, reads two sources from the register file (with
// write-first bypass from the same-cycle writeback), and presents registered
// operands A/B, the ALU select and the destination register.
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      alu_operand_stage_if.slave: in_* handshake, out_* operands,
//            wb_* writeback into the register file
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    alu_operand_stage_if.slave bus
);

    instr_t            dec;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              capture;

    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] alu_a_reg,     alu_a_next;
    logic [DATA_W-1:0] alu_b_reg,     alu_b_next;
    logic [SEL_W-1:0]  alu_sel_reg,   alu_sel_next;
    logic [ADDR_W-1:0] alu_dest_reg,  alu_dest_next;

    // Encoding bits with no meaning for this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.in_instr[31:28], bus.in_instr[23:19], bus.in_instr[15:11]};

    assign dec = decode_instr(bus.in_instr);

    alu_operand_stage_reg_file u_reg_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (dec.src1),
        .rd_data_a (rf_a),
        .rd_addr_b (dec.src2),
        .rd_data_b (rf_b),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data)
    );

    // Write-first bypass: a writeback landing on the same edge as the
    // capture must be seen by the captured operands.
    assign op_a = (bus.wb_en && (bus.wb_addr == dec.src1)) ? bus.wb_data : rf_a;
    assign op_b = dec.imm ? dec.imm8
                : ((bus.wb_en && (bus.wb_addr == dec.src2)) ? bus.wb_data : rf_b);

    // During reset the output register is about to clear, so the stage
    // reports ready; the reset branch below still blocks the capture.
    assign bus.in_ready = !reset_n || !out_valid_reg || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_next = out_valid_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_sel_next   = alu_sel_reg;
        alu_dest_next  = alu_dest_reg;
        if (capture) begin
            out_valid_next = 1'b1;
            alu_a_next     = op_a;
            alu_b_next     = op_b;
            alu_sel_next   = dec.sel;
            alu_dest_next  = dec.dest;
        end else if (bus.out_ready) begin
            // Operands keep their last value after a drain; only valid drops.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= '0;
            alu_dest_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_sel_reg   <= alu_sel_next;
            alu_dest_reg  <= alu_dest_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_sel   = alu_sel_reg;
    assign bus.alu_dest  = alu_dest_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed stimulus for alu_operand_stage. Expected operand sets are queued
// when an instruction is accepted; a monitor compares them with the DUT
// outputs whenever out_valid is high (held values while stalled, popped when
// consumed).
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if bus_if();

    alu_operand_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [2:0] dest;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] mk(input logic [2:0] sel, input logic imm,
                                       input logic [2:0] dest, input logic [2:0] src1,
                                       input logic [2:0] src2, input logic [7:0] imm8);
        logic [31:0] w;
        w = '0;
        w[26:24] = sel;
        w[27]    = imm;
        w[18:16] = dest;
        w[10:8]  = src1;
        if (imm) w[7:0] = imm8;
        else     w[2:0] = src2;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [7:0] data);
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = addr;
        bus_if.wb_data = data;
        step();
        bus_if.wb_en   = 1'b0;
    endtask

    // Present an instruction, wait (bounded) for acceptance, queue expectation.
    task automatic send(input logic [31:0] instr, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [2:0] es, input logic [2:0] ed);
        int n;
        exp_t e;
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = instr;
        n = 0;
        @(negedge clk);
        while (!bus_if.in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus_if.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout instr=%h actual in_ready=0 required 1", instr);
        end else begin
            e.a = ea; e.b = eb; e.sel = es; e.dest = ed;
            sb.push_back(e);
            $display("send instr=%h exp A=%h B=%h sel=%b dest=%0d", instr, ea, eb, es, ed);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && bus_if.out_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output actual A=%h B=%h sel=%b dest=%0d required none",
                         bus_if.alu_a, bus_if.alu_b, bus_if.alu_sel, bus_if.alu_dest);
            end else begin
                if ({bus_if.alu_a, bus_if.alu_b, bus_if.alu_sel, bus_if.alu_dest} !==
                    {sb[0].a, sb[0].b, sb[0].sel, sb[0].dest}) begin
                    bad++;
                    $display("FAIL operands actual A=%h B=%h sel=%b dest=%0d required A=%h B=%h sel=%b dest=%0d",
                             bus_if.alu_a, bus_if.alu_b, bus_if.alu_sel, bus_if.alu_dest,
                             sb[0].a, sb[0].b, sb[0].sel, sb[0].dest);
                end else begin
                    $display("out  A=%h B=%h sel=%b dest=%0d ready=%b",
                             bus_if.alu_a, bus_if.alu_b, bus_if.alu_sel, bus_if.alu_dest,
                             bus_if.out_ready);
                end
                if (bus_if.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_instr  = '0;
        bus_if.out_ready = 1'b1;
        bus_if.wb_en     = 1'b0;
        bus_if.wb_addr   = '0;
        bus_if.wb_data   = '0;

        // 1. Reset, fill registers, reset again with a pending instruction.
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) wb(3'(i), 8'(8'h10 + i));
        reset_n = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = mk(SEL_ADD, 1'b0, 3'd1, 3'd1, 3'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
            step();
            check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        end
        check("rst_alu_a", 32'(bus_if.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus_if.alu_b), 32'd0);
        check("rst_alu_sel", 32'(bus_if.alu_sel), 32'd0);
        check("rst_alu_dest", 32'(bus_if.alu_dest), 32'd0);
        bus_if.in_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++)
            send(mk(SEL_ADD, 1'b0, 3'(i), 3'(i), 3'((i + 1) % 8), 8'h00), 8'h00, 8'h00, SEL_ADD, 3'(i));

        // 2. Basic register-sourced add.
        wb(3'd1, 8'h05);
        wb(3'd2, 8'h03);
        send(mk(SEL_ADD, 1'b0, 3'd3, 3'd1, 3'd2, 8'h00), 8'h05, 8'h03, SEL_ADD, 3'd3);

        // 3. Bypass on both sources, then confirm R4 was written.
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 3'd4; bus_if.wb_data = 8'h7F;
        send(mk(SEL_XOR, 1'b0, 3'd0, 3'd4, 3'd4, 8'h00), 8'h7F, 8'h7F, SEL_XOR, 3'd0);
        bus_if.wb_en = 1'b0;
        send(mk(SEL_AND, 1'b0, 3'd1, 3'd4, 3'd0, 8'h00), 8'h7F, 8'h00, SEL_AND, 3'd1);

        // 4. Immediate; a writeback to the overlapping src2 field must not bypass into B.
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 3'd2; bus_if.wb_data = 8'h99;
        send(mk(SEL_SUB, 1'b1, 3'd2, 3'd1, 3'd0, 8'h02), 8'h05, 8'h02, SEL_SUB, 3'd2);
        bus_if.wb_en = 1'b0;

        // 5. Stall for 3 cycles with writebacks to the held instruction's sources.
        send(mk(SEL_ADD, 1'b0, 3'd5, 3'd1, 3'd2, 8'h00), 8'h05, 8'h99, SEL_ADD, 3'd5);
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_instr  = mk(SEL_XOR, 1'b0, 3'd6, 3'd1, 3'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            bus_if.wb_en   = (i < 2);
            bus_if.wb_addr = (i == 0) ? 3'd1 : 3'd2;
            bus_if.wb_data = (i == 0) ? 8'h11 : 8'h22;
            @(negedge clk);
            check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
            step();
        end
        bus_if.wb_en     = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus_if.in_ready), 32'd1);
        sb.push_back('{a: 8'h11, b: 8'h22, sel: SEL_XOR, dest: 3'd6});
        step();
        bus_if.in_valid = 1'b0;
        step(); step();
        check("drain_out_valid", 32'(bus_if.out_valid), 32'd0);

        // 6. Reset while stalled; pending writeback and instruction are dropped.
        bus_if.out_ready = 1'b0;
        send(mk(SEL_OR, 1'b0, 3'd7, 3'd1, 3'd2, 8'h00), 8'h11, 8'h22, SEL_OR, 3'd7);
        step();
        reset_n = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = mk(SEL_ADD, 1'b0, 3'd1, 3'd3, 3'd3, 8'h00);
        bus_if.wb_en = 1'b1; bus_if.wb_addr = 3'd3; bus_if.wb_data = 8'hAA;
        sb.delete();
        @(negedge clk);
        check("midrst_in_ready", 32'(bus_if.in_ready), 32'd1);
        step();
        reset_n = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.wb_en     = 1'b0;
        bus_if.out_ready = 1'b1;
        check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("midrst_alu_a", 32'(bus_if.alu_a), 32'd0);
        check("midrst_alu_b", 32'(bus_if.alu_b), 32'd0);
        send(mk(SEL_ADD, 1'b0, 3'd0, 3'd1, 3'd3, 8'h00), 8'h00, 8'h00, SEL_ADD, 3'd0);
        send(mk(SEL_ADD, 1'b0, 3'd0, 3'd2, 3'd4, 8'h00), 8'h00, 8'h00, SEL_ADD, 3'd0);

        step(); step(); step();
        check("final_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
